// File: rtl/game_sequencer.sv
// game_sequencer
// Top-level game-flow controller for a side-scrolling jump game.
// Tracks MENU/PLAY/WON/LOST, the player's jump height, the obstacle scroll
// position, the number of completed scroll wraps and a 31-bit LFSR that
// selects which obstacles are enabled on each lap.
//
// Ports
//   clk         : single clock
//   reset       : asynchronous active-low reset
//   game_tick   : one-cycle game-step enable
//   start_btn   : start/restart button (level, clk-synchronous)
//   jump_btn    : jump button (level, clk-synchronous)
//   hits        : collision flag from the video generator
//   menuScreen  : high in MENU
//   playerWon   : high in WON
//   playerLost  : high in LOST
//   distance    : player height above base level, pixels
//   obj_counter : obstacle scroll position
//   shapes      : obstacle enable pattern (current LFSR value)
//   laps        : completed scroll wraps
module game_sequencer #(
  parameter logic [9:0]  JUMP_MAX    = 10'd100,
  parameter logic [9:0]  WRAP_VAL    = 10'd700,
  parameter logic [3:0]  LAPS_TO_WIN = 4'd8,
  parameter logic [30:0] LFSR_SEED   = 31'h1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        game_tick,
  input  logic        start_btn,
  input  logic        jump_btn,
  input  logic        hits,
  output logic        menuScreen,
  output logic        playerWon,
  output logic        playerLost,
  output logic [9:0]  distance,
  output logic [9:0]  obj_counter,
  output logic [30:0] shapes,
  output logic [3:0]  laps
);

  typedef enum logic [1:0] {MENU, PLAY, WON, LOST} state_t;
  typedef enum logic [1:0] {GROUND, RISE, FALL} jump_t;

  state_t state;
  jump_t  jump_state;

  logic start_prev;
  logic jump_prev;
  // Low for the first clock after reset release. Suppresses edge detection
  // for that one sample so a button held through reset is seen as already
  // pressed rather than as a fresh press.
  logic armed;

  logic        start_edge;
  logic        jump_edge;
  logic        wrap_now;
  logic [3:0]  laps_inc;
  logic [30:0] lfsr_next;

  assign start_edge = armed & start_btn & ~start_prev;
  assign jump_edge  = armed & jump_btn & ~jump_prev;

  // >= rather than == so an out-of-range count can never run past the wrap.
  assign wrap_now = (obj_counter >= (WRAP_VAL - 10'd1));
  assign laps_inc = laps + 4'd1;

  // Fibonacci LFSR, x^31 + x^28 + 1: feedback from bits 31 and 28 (1-based).
  assign lfsr_next = {shapes[29:0], shapes[30] ^ shapes[27]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= MENU;
      jump_state  <= GROUND;
      menuScreen  <= 1'b1;
      playerWon   <= 1'b0;
      playerLost  <= 1'b0;
      distance    <= '0;
      obj_counter <= '0;
      laps        <= '0;
      shapes      <= LFSR_SEED;
      start_prev  <= 1'b0;
      jump_prev   <= 1'b0;
      armed       <= 1'b0;
    end else begin
      armed      <= 1'b1;
      start_prev <= start_btn;
      jump_prev  <= jump_btn;

      case (state)
        MENU: begin
          // The LFSR deliberately keeps its value so each game sees a
          // different obstacle sequence.
          if (start_edge) begin
            state       <= PLAY;
            menuScreen  <= 1'b0;
            distance    <= '0;
            obj_counter <= '0;
            laps        <= '0;
            jump_state  <= GROUND;
          end
        end

        PLAY: begin
          // A collision wins over everything else in the same cycle,
          // including a winning wrap; the play field freezes as it was.
          if (hits) begin
            state      <= LOST;
            playerLost <= 1'b1;
          end else begin
            if (game_tick) begin
              if (wrap_now) begin
                obj_counter <= '0;
                laps        <= laps_inc;
                shapes      <= lfsr_next;
                if (laps_inc == LAPS_TO_WIN) begin
                  state     <= WON;
                  playerWon <= 1'b1;
                end
              end else begin
                obj_counter <= obj_counter + 10'd1;
              end
            end

            // Jump edges are only honoured on the ground, so no double jump.
            case (jump_state)
              GROUND: begin
                if (jump_edge) jump_state <= RISE;
              end
              RISE: begin
                if (game_tick) begin
                  if (distance >= JUMP_MAX) begin
                    jump_state <= FALL;
                  end else begin
                    distance <= distance + 10'd1;
                    if ((distance + 10'd1) == JUMP_MAX) jump_state <= FALL;
                  end
                end
              end
              FALL: begin
                if (game_tick) begin
                  if (distance == 10'd0) begin
                    jump_state <= GROUND;
                  end else begin
                    distance <= distance - 10'd1;
                    if (distance == 10'd1) jump_state <= GROUND;
                  end
                end
              end
              default: jump_state <= GROUND;
            endcase
          end
        end

        WON, LOST: begin
          if (start_edge) begin
            state      <= MENU;
            menuScreen <= 1'b1;
            playerWon  <= 1'b0;
            playerLost <= 1'b0;
          end
        end

        default: begin
          state      <= MENU;
          menuScreen <= 1'b1;
          playerWon  <= 1'b0;
          playerLost <= 1'b0;
        end
      endcase
    end
  end

endmodule
